// File: rtl/bless_brouter.sv
// Bufferless deflection router, 5 ports (N,S,E,W,local), oldest-first allocation, 2-cycle latency.
// Optional macro BROUTER_AGE_INC_EN: outgoing flits get age+1 (saturating).
module bless_brouter #(
   parameter int unsigned SEQ_W   = 3,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned AGE_W   = 4,
   parameter int unsigned DATA_W  = 8,
   parameter logic [ADDR_W-1:0] MY_ADDR = 4'b0101,
   localparam int unsigned CTRL_W = 1 + SEQ_W + 2 * ADDR_W + AGE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTRL_W-1:0] port0_ci,
   input  logic [CTRL_W-1:0] port1_ci,
   input  logic [CTRL_W-1:0] port2_ci,
   input  logic [CTRL_W-1:0] port3_ci,
   input  logic [CTRL_W-1:0] port4_ci,
   input  logic [DATA_W-1:0] port0_di,
   input  logic [DATA_W-1:0] port1_di,
   input  logic [DATA_W-1:0] port2_di,
   input  logic [DATA_W-1:0] port3_di,
   input  logic [DATA_W-1:0] port4_di,
   output logic [CTRL_W-1:0] port0_co,
   output logic [CTRL_W-1:0] port1_co,
   output logic [CTRL_W-1:0] port2_co,
   output logic [CTRL_W-1:0] port3_co,
   output logic [CTRL_W-1:0] port4_co,
   output logic [DATA_W-1:0] port0_do,
   output logic [DATA_W-1:0] port1_do,
   output logic [DATA_W-1:0] port2_do,
   output logic [DATA_W-1:0] port3_do,
   output logic [DATA_W-1:0] port4_do,
   output logic              port4_ready
);

   localparam int unsigned BodyW   = CTRL_W - 1;
   localparam int unsigned VldBit  = CTRL_W - 1;
   localparam int unsigned DestLsb = AGE_W;
   localparam int unsigned HalfW   = ADDR_W / 2;

   logic [CTRL_W-1:0] in_ctrl [5];
   logic [DATA_W-1:0] in_data [5];

   assign in_ctrl[0] = port0_ci;
   assign in_ctrl[1] = port1_ci;
   assign in_ctrl[2] = port2_ci;
   assign in_ctrl[3] = port3_ci;
   assign in_ctrl[4] = port4_ci;
   assign in_data[0] = port0_di;
   assign in_data[1] = port1_di;
   assign in_data[2] = port2_di;
   assign in_data[3] = port3_di;
   assign in_data[4] = port4_di;

   function automatic logic [AGE_W-1:0] age_out(input logic [AGE_W-1:0] a);
`ifdef BROUTER_AGE_INC_EN
      return (&a) ? a : a + 1'b1;
`else
      return a;
`endif
   endfunction

   // Injection is safe if a network output is left over, or an arriving flit ejects.
   logic [3:0] net_vld;
   logic [3:0] net_here;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         net_vld[i]  = in_ctrl[i][VldBit];
         net_here[i] = net_vld[i] && (in_ctrl[i][DestLsb +: ADDR_W] == MY_ADDR);
      end
      port4_ready = !(&net_vld) || (|net_here);
   end

   // Stage 1
   logic [4:0]        s1_vld_q;
   logic [BodyW-1:0]  s1_body_q [5];
   logic [DATA_W-1:0] s1_data_q [5];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= '0;
         for (int i = 0; i < 5; i++) begin
            s1_body_q[i] <= '0;
            s1_data_q[i] <= '0;
         end
      end else begin
         s1_vld_q[3:0] <= net_vld;
         s1_vld_q[4]   <= in_ctrl[4][VldBit] & port4_ready;
         for (int i = 0; i < 5; i++) begin
            s1_body_q[i] <= in_ctrl[i][BodyW-1:0];
            s1_data_q[i] <= in_data[i];
         end
      end
   end

   // Route compute: rmatrix bit order N,S,E,W matches output port index
   logic [3:0]       rmatrix [5];
   logic [AGE_W-1:0] age     [5];

   always_comb begin
      logic [ADDR_W-1:0] dest;
      for (int i = 0; i < 5; i++) begin
         dest          = s1_body_q[i][DestLsb +: ADDR_W];
         age[i]        = s1_body_q[i][AGE_W-1:0];
         rmatrix[i][0] = dest[ADDR_W-1:HalfW] < MY_ADDR[ADDR_W-1:HalfW];
         rmatrix[i][1] = dest[ADDR_W-1:HalfW] > MY_ADDR[ADDR_W-1:HalfW];
         rmatrix[i][2] = dest[HalfW-1:0] > MY_ADDR[HalfW-1:0];
         rmatrix[i][3] = dest[HalfW-1:0] < MY_ADDR[HalfW-1:0];
      end
   end

   // Ejection winner: oldest destined-here network flit, lower port on ties
   logic             eject_found;
   logic [2:0]       eject_idx;
   logic [AGE_W-1:0] eject_age;

   always_comb begin
      eject_found = 1'b0;
      eject_idx   = '0;
      eject_age   = '0;
      for (int i = 0; i < 4; i++) begin
         if (s1_vld_q[i] && (rmatrix[i] == 4'b0000) && (!eject_found || age[i] > eject_age)) begin
            eject_found = 1'b1;
            eject_idx   = 3'(i);
            eject_age   = age[i];
         end
      end
   end

   // Allocation: repeatedly pick the oldest unserved flit and give it an output
   logic [2:0] route_sel_d [5];
   logic [4:0] route_vld_d;

   always_comb begin
      logic [4:0]       done;
      logic [4:0]       busy;
      logic             found;
      logic             placed;
      logic [2:0]       best;
      logic [AGE_W-1:0] best_age;
      done        = '0;
      busy        = '0;
      route_vld_d = '0;
      for (int o = 0; o < 5; o++) route_sel_d[o] = '0;
      for (int k = 0; k < 5; k++) begin
         found    = 1'b0;
         best     = '0;
         best_age = '0;
         placed   = 1'b0;
         for (int i = 0; i < 5; i++) begin
            if (s1_vld_q[i] && !done[i] && (!found || age[i] > best_age)) begin
               found    = 1'b1;
               best     = 3'(i);
               best_age = age[i];
            end
         end
         if (found) begin
            done[best] = 1'b1;
            if (eject_found && (best == eject_idx)) begin
               route_sel_d[4] = best;
               route_vld_d[4] = 1'b1;
               busy[4]        = 1'b1;
            end else begin
               for (int o = 0; o < 4; o++) begin
                  if (!placed && !busy[o] && rmatrix[best][o]) begin
                     route_sel_d[o] = best;
                     route_vld_d[o] = 1'b1;
                     busy[o]        = 1'b1;
                     placed         = 1'b1;
                  end
               end
               // No productive output left: deflect
               for (int o = 0; o < 4; o++) begin
                  if (!placed && !busy[o]) begin
                     route_sel_d[o] = best;
                     route_vld_d[o] = 1'b1;
                     busy[o]        = 1'b1;
                     placed         = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Stage 2: route_config plus the flits it selects from; crossbar follows the registers
   logic [2:0]        route_sel_q [5];
   logic [4:0]        route_vld_q;
   logic [BodyW-1:0]  s2_body_q   [5];
   logic [DATA_W-1:0] s2_data_q   [5];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         route_vld_q <= '0;
         for (int i = 0; i < 5; i++) begin
            route_sel_q[i] <= '0;
            s2_body_q[i]   <= '0;
            s2_data_q[i]   <= '0;
         end
      end else begin
         route_vld_q <= route_vld_d;
         for (int i = 0; i < 5; i++) begin
            route_sel_q[i] <= route_sel_d[i];
            s2_body_q[i]   <= {s1_body_q[i][BodyW-1:AGE_W], age_out(age[i])};
            s2_data_q[i]   <= s1_data_q[i];
         end
      end
   end

   logic [CTRL_W-1:0] out_ctrl [5];
   logic [DATA_W-1:0] out_data [5];

   always_comb begin
      for (int o = 0; o < 5; o++) begin
         out_ctrl[o] = '0;
         out_data[o] = '0;
         if (route_vld_q[o]) begin
            out_ctrl[o] = {1'b1, s2_body_q[route_sel_q[o]]};
            out_data[o] = s2_data_q[route_sel_q[o]];
         end
      end
   end

   assign port0_co = out_ctrl[0];
   assign port1_co = out_ctrl[1];
   assign port2_co = out_ctrl[2];
   assign port3_co = out_ctrl[3];
   assign port4_co = out_ctrl[4];
   assign port0_do = out_data[0];
   assign port1_do = out_data[1];
   assign port2_do = out_data[2];
   assign port3_do = out_data[3];
   assign port4_do = out_data[4];

endmodule

// File: tb/tb_bless_brouter.sv
// Directed bench for bless_brouter: expected output maps are queued at drive time and
// compared two edges later.
module tb_bless_brouter;

   logic        clk;
   logic        rst;
   logic [15:0] ci   [5];
   logic [7:0]  di   [5];
   logic [15:0] co   [5];
   logic [7:0]  dout [5];
   logic        ready;

   typedef struct packed {
      logic [79:0] c;
      logic [39:0] d;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   fails;

   bless_brouter dut (
      .clk         (clk),
      .rst         (rst),
      .port0_ci    (ci[0]),
      .port1_ci    (ci[1]),
      .port2_ci    (ci[2]),
      .port3_ci    (ci[3]),
      .port4_ci    (ci[4]),
      .port0_di    (di[0]),
      .port1_di    (di[1]),
      .port2_di    (di[2]),
      .port3_di    (di[3]),
      .port4_di    (di[4]),
      .port0_co    (co[0]),
      .port1_co    (co[1]),
      .port2_co    (co[2]),
      .port3_co    (co[3]),
      .port4_co    (co[4]),
      .port0_do    (dout[0]),
      .port1_do    (dout[1]),
      .port2_do    (dout[2]),
      .port3_do    (dout[3]),
      .port4_do    (dout[4]),
      .port4_ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] f(input logic v, input logic [2:0] seq, input logic [3:0] src,
                                     input logic [3:0] dest, input logic [3:0] age);
      return {v, seq, src, dest, age};
   endfunction

   function automatic logic [15:0] leave(input logic [15:0] c);
      logic [15:0] r;
      r = c;
`ifdef BROUTER_AGE_INC_EN
      if (r[3:0] != 4'hF) r[3:0] = r[3:0] + 4'd1;
`endif
      return r;
   endfunction

   // m<o> = input port expected on output o, 7 = output idle
   task automatic push_map(input logic [2:0] m0, input logic [2:0] m1, input logic [2:0] m2,
                           input logic [2:0] m3, input logic [2:0] m4);
      exp_t e;
      logic [2:0] m [5];
      m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3; m[4] = m4;
      e = '0;
      for (int o = 0; o < 5; o++) begin
         if (m[o] != 3'd7) begin
            e.c[o*16 +: 16] = leave(ci[m[o]]);
            e.d[o*8 +: 8]   = di[m[o]];
         end
      end
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() >= 2) begin
         e = sb.pop_front();
         for (int o = 0; o < 5; o++) begin
            checks++;
            assert ({co[o], dout[o]} === {e.c[o*16 +: 16], e.d[o*8 +: 8]}) else begin
               fails++;
               $error("FAIL out%0d got=%h/%h exp=%h/%h", o, co[o], dout[o],
                      e.c[o*16 +: 16], e.d[o*8 +: 8]);
            end
         end
      end
   endtask

   task automatic chk_ready(input logic exp_r, input string tag);
      #1;
      checks++;
      assert (ready === exp_r) else begin
         fails++;
         $error("FAIL ready_%s got=%b exp=%b", tag, ready, exp_r);
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int o = 0; o < 5; o++) begin
         checks++;
         assert ({co[o], dout[o]} === 24'h0) else begin
            fails++;
            $error("FAIL %s out%0d got=%h/%h exp=0/0", tag, o, co[o], dout[o]);
         end
      end
   endtask

   task automatic idle();
      for (int i = 0; i < 5; i++) begin
         ci[i] = f(1'b0, 3'd7, 4'hF, 4'h5, 4'hF);
         di[i] = 8'hEE;
      end
   endtask

   task automatic case1();
      ci[0] = f(1'b1, 3'd0, 4'h1, 4'b0001, 4'd0); di[0] = 8'h10;
      ci[1] = f(1'b1, 3'd1, 4'h2, 4'b0100, 4'd0); di[1] = 8'h11;
      ci[2] = f(1'b1, 3'd2, 4'h3, 4'b0011, 4'd0); di[2] = 8'h12;
      ci[3] = f(1'b1, 3'd3, 4'h4, 4'b1100, 4'd0); di[3] = 8'h13;
      ci[4] = f(1'b1, 3'd4, 4'h5, 4'b0110, 4'd0); di[4] = 8'h44;
   endtask

   task automatic case3();
      ci[0] = f(1'b1, 3'd0, 4'h1, 4'b1111, 4'd10); di[0] = 8'h20;
      ci[1] = f(1'b1, 3'd1, 4'h2, 4'b0000, 4'd11); di[1] = 8'h21;
      ci[2] = f(1'b1, 3'd2, 4'h3, 4'b1111, 4'd9);  di[2] = 8'h22;
      ci[3] = f(1'b1, 3'd3, 4'h4, 4'b0000, 4'd9);  di[3] = 8'h23;
      ci[4] = f(1'b0, 3'd4, 4'h5, 4'b0110, 4'd15); di[4] = 8'h99;
   endtask

   task automatic case4();
      ci[0] = f(1'b1, 3'd0, 4'h1, 4'b0101, 4'd10); di[0] = 8'h30;
      ci[1] = f(1'b1, 3'd1, 4'h2, 4'b0101, 4'd11); di[1] = 8'h31;
      ci[2] = f(1'b1, 3'd2, 4'h3, 4'b0101, 4'd9);  di[2] = 8'h32;
      ci[3] = f(1'b1, 3'd3, 4'h4, 4'b0101, 4'd9);  di[3] = 8'h33;
      ci[4] = f(1'b1, 3'd4, 4'h5, 4'b0110, 4'd0);  di[4] = 8'h45;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ci[i] = '0;
         di[i] = '0;
      end
      #2;
      chk_zero("reset");
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;

      // Full network load, local must be held back
      case1();
      chk_ready(1'b0, "full");
      push_map(3'd0, 3'd3, 3'd2, 3'd1, 3'd7);
      step();

      // Port 2 idle: held local flit is accepted and takes East
      ci[2] = f(1'b0, 3'd2, 4'h3, 4'b0011, 4'd0);
      chk_ready(1'b1, "gap");
      push_map(3'd0, 3'd3, 3'd4, 3'd1, 3'd7);
      step();

      // Age priority, tie between ports 2 and 3
      case3();
      chk_ready(1'b0, "ages");
      push_map(3'd1, 3'd0, 3'd2, 3'd3, 3'd7);
      step();

      // All destined here: oldest ejects, rest deflect, local fills last output
      case4();
      chk_ready(1'b1, "here");
      push_map(3'd0, 3'd2, 3'd3, 3'd4, 3'd1);
      step();

      // Single max-age flit ejects
      idle();
      ci[0] = f(1'b1, 3'd5, 4'h9, 4'b0101, 4'd15); di[0] = 8'h50;
      chk_ready(1'b1, "single");
      push_map(3'd7, 3'd7, 3'd7, 3'd7, 3'd0);
      step();

      // Invalid flits with non-zero fields are ignored
      idle();
      chk_ready(1'b1, "idle");
      push_map(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
      step();
      push_map(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
      step();
      push_map(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
      step();

      // Reset in the middle of traffic
      case1();
      push_map(3'd0, 3'd3, 3'd2, 3'd1, 3'd7);
      step();
      case3();
      push_map(3'd1, 3'd0, 3'd2, 3'd3, 3'd7);
      step();
      #2;
      rst = 1'b1;
      #1;
      chk_zero("rst_async");
      sb.delete();
      idle();
      @(posedge clk);
      #1;
      chk_zero("rst_held");
      #3;
      rst = 1'b0;

      case4();
      push_map(3'd0, 3'd2, 3'd3, 3'd4, 3'd1);
      step();
      chk_zero("early");
      idle();
      push_map(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
      step();
      push_map(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
